sme_param: RTL and testbench

SME_PARAM -- requirements
Module: sme_param

---
 rtl/sme_param.sv | 147 ++++++++++++++
 tb/tb_sme_param.sv | 136 +++++++++++++
 2 files changed

// File: rtl/sme_param.sv
// sme_param: string buffer plus wildcard pattern matcher ('.', '*', '^', '$') reporting the leftmost match start.
module sme_param #(
   parameter int STR_MAX = 32,
   parameter int PAT_MAX = 8,
   parameter int CHAR_W  = 8,
   parameter int IDX_W   = $clog2(STR_MAX)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [CHAR_W-1:0] chardata,
   input  logic              isstring,
   input  logic              ispattern,
   output logic              valid,
   output logic              match,
   output logic [IDX_W-1:0]  match_index,
   output logic              busy
);
   localparam int LW = IDX_W + 1;
   localparam int PI = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
   localparam int PW = PI + 1;
   localparam logic [LW-1:0] SMAX = LW'(STR_MAX);
   localparam logic [PW-1:0] PMAX = PW'(PAT_MAX);
   localparam logic [2:0] IDLE = 3'd0, LOAD_STR = 3'd1, LOAD_PAT = 3'd2, SCAN = 3'd3, DONE = 3'd4;
   localparam logic [CHAR_W-1:0] C_DOT = CHAR_W'(8'h2E), C_STAR = CHAR_W'(8'h2A),
      C_CARET = CHAR_W'(8'h5E), C_DOLLAR = CHAR_W'(8'h24), C_SP = CHAR_W'(8'h20);

   logic [2:0]        state;
   logic [CHAR_W-1:0] str_mem [STR_MAX];
   logic [CHAR_W-1:0] pat_mem [PAT_MAX];
   logic [LW-1:0]     str_len, t, i, star_i;
   logic [PW-1:0]     pat_len, j, star_j;
   logic              star_seen, skip;

   logic pat_stb, accept, str_we, pat_we;
   logic [IDX_W-1:0] str_wa;
   logic [PI-1:0]    pat_wa;
   logic [CHAR_W-1:0] pc, sc;
   logic in_str, sp, is_star, is_caret, is_dollar, is_dot, ok, adv, pat_done;

   assign pat_stb = ispattern & ~isstring;
   assign accept  = (state == IDLE) | (state == DONE);
   assign str_we  = isstring & (accept | (state == LOAD_STR & str_len < SMAX));
   assign str_wa  = accept ? '0 : str_len[IDX_W-1:0];
   assign pat_we  = pat_stb & (accept | state == LOAD_STR | (state == LOAD_PAT & pat_len < PMAX));
   assign pat_wa  = (state == LOAD_PAT) ? pat_len[PI-1:0] : '0;

   assign pc        = pat_mem[j[PI-1:0]];
   assign sc        = str_mem[i[IDX_W-1:0]];
   assign in_str    = i < str_len;
   assign sp        = in_str & (sc == C_SP);
   assign is_star   = pc == C_STAR;
   assign is_caret  = pc == C_CARET;
   assign is_dollar = pc == C_DOLLAR;
   assign is_dot    = pc == C_DOT;
   assign pat_done  = j == pat_len;
   // '^' is zero-width at string start, otherwise it consumes one space; '$' never consumes
   assign ok  = is_star | (is_caret ? (i == '0) | sp : is_dollar ? ~in_str | sp : is_dot ? in_str : in_str & (sc == pc));
   assign adv = ~is_star & ~is_dollar & ~(is_caret & i == '0);

   assign valid = state == DONE;
   assign busy  = state == SCAN;

   always_ff @(posedge clk) begin
      if (str_we) str_mem[str_wa] <= chardata;
      if (pat_we) pat_mem[pat_wa] <= chardata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         str_len     <= '0;
         pat_len     <= '0;
         t           <= '0;
         i           <= '0;
         j           <= '0;
         star_i      <= '0;
         star_j      <= '0;
         star_seen   <= 1'b0;
         skip        <= 1'b0;
         match       <= 1'b0;
         match_index <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (isstring) begin
                  state   <= LOAD_STR;
                  str_len <= LW'(1);
               end else if (pat_stb) begin
                  state   <= LOAD_PAT;
                  pat_len <= PW'(1);
               end else state <= IDLE;
            end
            LOAD_STR: begin
               if (isstring) begin
                  if (str_len < SMAX) str_len <= str_len + 1'b1;
               end else if (pat_stb) begin
                  state   <= LOAD_PAT;
                  pat_len <= PW'(1);
               end else state <= IDLE;
            end
            LOAD_PAT: begin
               if (pat_stb) begin
                  if (pat_len < PMAX) pat_len <= pat_len + 1'b1;
               end else begin
                  state     <= SCAN;
                  t         <= '0;
                  i         <= '0;
                  j         <= '0;
                  star_seen <= 1'b0;
                  skip      <= 1'b0;
               end
            end
            SCAN: begin
               if (pat_done) begin
                  state       <= DONE;
                  match       <= 1'b1;
                  match_index <= IDX_W'(t + LW'(skip));
               end else if (ok) begin
                  j <= j + 1'b1;
                  if (adv) i <= i + 1'b1;
                  if (is_star) begin
                     star_seen <= 1'b1;
                     star_i    <= i;
                     star_j    <= j;
                  end
                  if (is_caret & adv & j == '0) skip <= 1'b1;
               end else if (star_seen & star_i < str_len) begin
                  // let the star swallow one more character and retry the suffix
                  star_i <= star_i + 1'b1;
                  i      <= star_i + 1'b1;
                  j      <= star_j + 1'b1;
               end else if (~star_seen & t < str_len) begin
                  t    <= t + 1'b1;
                  i    <= t + 1'b1;
                  j    <= '0;
                  skip <= 1'b0;
               end else begin
                  state       <= DONE;
                  match       <= 1'b0;
                  match_index <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sme_param.sv
// tb_sme_param: directed checks of sme_param loading, wildcard matching, reset abort and busy protection.
module tb_sme_param;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] chardata = '0;
   logic       isstring = 1'b0;
   logic       ispattern = 1'b0;
   logic       valid, match, busy;
   logic [4:0] match_index;
   int checks = 0;
   int fails = 0;

   sme_param dut (
      .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
      .valid(valid), .match(match), .match_index(match_index), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic send(input string s, input logic p);
      for (int k = 0; k < s.len(); k++) begin
         chardata  = s[k];
         isstring  = ~p;
         ispattern = p;
         @(negedge clk);
      end
      isstring  = 1'b0;
      ispattern = 1'b0;
   endtask

   task automatic pat(input string s);
      send(s, 1'b1);
      @(negedge clk);
      chk({s, " busy"}, busy, 1);
   endtask

   task automatic result(input string tag, input logic em, input logic [4:0] ei);
      int n = 0;
      while (!valid && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " valid"}, valid, 1);
      chk({tag, " match"}, match, em);
      chk({tag, " index"}, match_index, ei);
      @(negedge clk);
      chk({tag, " pulse"}, valid, 0);
      chk({tag, " hold"}, match, em);
      chk({tag, " idle"}, busy, 0);
   endtask

   initial begin
      string long_s;
      int nv;
      repeat (2) @(negedge clk);
      chk("rst valid", valid, 0);
      chk("rst match", match, 0);
      chk("rst index", match_index, 0);
      chk("rst busy", busy, 0);
      reset = 1'b0;
      @(negedge clk);

      send("this is a book", 1'b0);
      pat("^is");
      result("^is", 1'b1, 5'd5);
      pat("o.k");
      result("o.k", 1'b1, 5'd11);
      pat("ok$");
      result("ok$", 1'b1, 5'd12);
      pat("t*s");
      result("t*s", 1'b1, 5'd0);
      pat("xyz");
      result("xyz", 1'b0, 5'd0);
      pat("book$");
      result("book$", 1'b1, 5'd10);
      pat("*ok");
      result("*ok", 1'b1, 5'd0);

      long_s = "";
      for (int k = 0; k < 37; k++) long_s = {long_s, "x"};
      long_s = {long_s, "abc"};
      send(long_s, 1'b0);
      pat("abc");
      result("trunc", 1'b0, 5'd0);
      send("abc", 1'b0);
      pat("abc");
      result("short", 1'b1, 5'd0);

      send("this is a book", 1'b0);
      pat("book$");
      result("pre-abort", 1'b1, 5'd10);
      pat("xyz");
      repeat (2) @(negedge clk);
      chk("scan busy", busy, 1);
      reset = 1'b1;
      #1;
      chk("abort valid", valid, 0);
      chk("abort match", match, 0);
      chk("abort index", match_index, 0);
      chk("abort busy", busy, 0);
      @(negedge clk);
      reset = 1'b0;
      nv = 0;
      repeat (200) begin
         @(negedge clk);
         if (valid) nv++;
      end
      chk("no valid after abort", nv, 0);
      send("this is a book", 1'b0);
      pat("^is");
      result("post-abort", 1'b1, 5'd5);

      send("hello world", 1'b0);
      pat("wor");
      chardata = "z";
      isstring = 1'b1;
      @(negedge clk);
      isstring = 1'b0;
      result("ignored", 1'b1, 5'd6);
      pat("d$");
      result("retained", 1'b1, 5'd10);
      pat("o.w");
      result("o.w", 1'b1, 5'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
